vector_deser: RTL and testbench
===============================

# vector_deser

Serial-to-parallel capture stage that feeds the 8-bit `data` input of the vector-processing top (`vector_Vtop`). It assembles a framed serial bit stream into a WIDTH-bit word with optional even-parity checking. It presents the word on a registered, held output with a one-cycle completion strobe, so the downstream combinational vector logic always sees a stable vector.

## Interface
- WIDTH, 8, data word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- PARITY_EN, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame-start pulse; accepted in any state.
- bit_en  input  1  qualifies ser_in as a valid bit this cycle.
- ser_in  input  1  serial data bit.
- data_out  output  WIDTH  last completed word; connects directly to the downstream `data` input.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- parity_err  output  1  one-cycle pulse coincident with data_valid when the parity check fails.
- frame_err  output  1  one-cycle pulse when start aborts a frame in progress.
- busy  output  1  high while in SHIFT or PAR.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: collecting data bits.
  - PAR: collecting the parity bit; used only when PARITY_EN=1.
- Reset:
  - State goes to IDLE; bit counter and shift register clear.
  - data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0.
- IDLE:
  - bit_en and ser_in are ignored.
  - start moves to SHIFT with counter=0.
  - ser_in is never sampled in the cycle start is asserted.
- SHIFT:
  - Each cycle with bit_en=1 shifts ser_in into the shift register and increments the counter. Cycles with bit_en=0 hold.
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - When the WIDTH-th bit is accepted:
    - PARITY_EN=0: go to IDLE and complete the frame.
    - PARITY_EN=1: go to PAR.
- PAR:
  - The first cycle with bit_en=1 samples the parity bit, goes to IDLE and completes the frame.
- Frame completion, on the same edge:
  - data_out is loaded with the assembled word.
  - data_valid=1.
  - parity_err=1 if PARITY_EN=1 and the parity bit differs from the XOR of the data bits.
  - data_out is updated even when parity fails.
- start while busy (SHIFT or PAR):
  - Frame is aborted; frame_err pulses.
  - Counter resets to 0; state goes to SHIFT, so a new frame begins.
  - data_out is unchanged and data_valid is not asserted.
  - start takes priority over bit_en in that cycle; the bit is discarded.
- start in the cycle the final bit is accepted: this is an abort. frame_err pulses and no completion occurs.
- data_out holds its value indefinitely between completions.

## Timing
- Completion latency: data_out and data_valid change at the clock edge that samples the final bit (last data bit, or the parity bit). Both are visible in the cycle after the final bit is presented.
- Minimum frame length:
  - PARITY_EN=1: 1 start cycle + WIDTH+1 bit cycles.
  - PARITY_EN=0: 1 start cycle + WIDTH bit cycles.
- Back-to-back frames: start may be asserted in the cycle data_valid is high. That start is taken from IDLE, so frame_err stays 0.
- data_valid, parity_err and frame_err are registered single-cycle pulses and never stretch.
- busy is registered:
  - Rises the cycle after start.
  - Falls in the same cycle data_valid rises.
- rst asserted mid-frame: the partial frame is discarded and all outputs go to reset values on the next edge. No pulses occur in the reset cycle.

## Test plan
- Nominal frame (WIDTH=8, MSB_FIRST=1, PARITY_EN=1):
  - Stimulus: start, then bits 1,0,1,0,0,1,0,1 and parity 0, bit_en=1 every cycle.
  - Required: data_out=0xA5; data_valid pulses exactly once, 9 bit-cycles after start; parity_err=0; busy high for exactly 9 cycles.
- Bad parity: same as the nominal frame but parity bit=1. Required: data_out=0xA5, data_valid=1 and parity_err=1 in the same cycle.
- Gapped bits, LSB-first:
  - Stimulus: MSB_FIRST=0; 0x3C sent LSB-first with bit_en=0 on every other cycle.
  - Required: data_out=0x3C; the gaps only stretch latency.
- Abort: start, 4 bits, start again, then a full 0x5A frame.
  - Required: one frame_err pulse; a single data_valid; data_out=0x5A.
  - data_out keeps its previous value (0xA5 from the first scenario) until that completion.
- Reset mid-frame and idle noise:
  - rst asserted after 3 bits: all outputs return to 0.
  - bit_en toggling in IDLE without start: no data_valid and no state change.
- Back-to-back: start asserted in the data_valid cycle of frame 1 (0xFF), then frame 2 (0x00). Required: two data_valid pulses, data_out=0xFF then 0x00, frame_err never asserted.

Source files
------------

// File: rtl/vector_deser.sv
// vector_deser: framed serial-to-parallel capture with optional even parity and held output word
module vector_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             bit_en_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             data_valid_o,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, shifted;
  logic             valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, busy_q;
  always_comb begin
    shifted = MSB_FIRST != 0 ? {shreg_q[WIDTH-2:0], ser_in_i} : {ser_in_i, shreg_q[WIDTH-1:1]};
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    // start wins over any bit presented in the same cycle, including the final one
    if (start_i) begin
      ferr_d  = state_q != IDLE;
      state_d = SHIFT;
      cnt_d   = '0;
      shreg_d = '0;
    end else if (bit_en_i && state_q == SHIFT) begin
      shreg_d = shifted;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = PARITY_EN != 0 ? PAR : IDLE;
        data_d  = PARITY_EN != 0 ? data_q : shifted;
        valid_d = PARITY_EN == 0;
      end
    end else if (bit_en_i && state_q == PAR) begin
      state_d = IDLE;
      data_d  = shreg_q;
      valid_d = 1'b1;
      perr_d  = ser_in_i ^ (^shreg_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= state_d != IDLE;
    end
  end
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_vector_deser.sv
// tb_vector_deser: vector table, directed corner sequences and random traffic against a frame-level model
module tb_vector_deser;
  logic clk = 1'b0, rst = 1'b0;
  logic st_a = 1'b0, be_a = 1'b0, si_a = 1'b0, st_b = 1'b0, be_b = 1'b0, si_b = 1'b0;
  logic [7:0] do_a, do_b;
  logic dv_a, pe_a, fe_a, bz_a, dv_b, pe_b, fe_b, bz_b;
  int tests = 0, fails = 0;

  vector_deser #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst(rst), .start_i(st_a), .bit_en_i(be_a), .ser_in_i(si_a),
    .data_out_o(do_a), .data_valid_o(dv_a), .parity_err_o(pe_a), .frame_err_o(fe_a), .busy_o(bz_a));
  vector_deser #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .start_i(st_b), .bit_en_i(be_b), .ser_in_i(si_b),
    .data_out_o(do_b), .data_valid_o(dv_b), .parity_err_o(pe_b), .frame_err_o(fe_b), .busy_o(bz_b));

  always #5 clk = ~clk;

  // frame-level reference: collected bits per instance, word built arithmetically on completion
  bit   msb_m[2] = '{1'b1, 1'b0};
  int   par_m[2] = '{1, 0};
  bit   rx[2][9];
  int   nrx[2];
  bit   in_frame[2];
  logic [7:0] e_data[2];
  bit   e_valid[2], e_perr[2], e_ferr[2], e_busy[2];

  task automatic model(input int k, input bit s, input bit b, input bit i, input bit r);
    logic [7:0] w;
    e_valid[k] = 0; e_perr[k] = 0; e_ferr[k] = 0;
    if (r) begin
      in_frame[k] = 0; nrx[k] = 0; e_data[k] = 8'h00;
    end else if (s) begin
      e_ferr[k] = in_frame[k]; in_frame[k] = 1; nrx[k] = 0;
    end else if (in_frame[k] && b) begin
      rx[k][nrx[k]] = i;
      nrx[k]++;
      if (nrx[k] == 8 + par_m[k]) begin
        w = 8'h00;
        for (int j = 0; j < 8; j++) w = w + (8'(rx[k][j]) << (msb_m[k] ? 7 - j : j));
        e_data[k]   = w;
        e_valid[k]  = 1;
        e_perr[k]   = par_m[k] == 1 && rx[k][8] != ^w;
        in_frame[k] = 0;
      end
    end
    e_busy[k] = in_frame[k];
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit sa, input bit ba, input bit ia, input bit sb, input bit bb, input bit ib, input bit r);
    st_a = sa; be_a = ba; si_a = ia; st_b = sb; be_b = bb; si_b = ib; rst = r;
    @(posedge clk);
    model(0, sa, ba, ia, r);
    model(1, sb, bb, ib, r);
    #1;
    check("a.data_out", do_a, e_data[0]);
    check("a.data_valid", 8'(dv_a), 8'(e_valid[0]));
    check("a.parity_err", 8'(pe_a), 8'(e_perr[0]));
    check("a.frame_err", 8'(fe_a), 8'(e_ferr[0]));
    check("a.busy", 8'(bz_a), 8'(e_busy[0]));
    check("b.data_out", do_b, e_data[1]);
    check("b.data_valid", 8'(dv_b), 8'(e_valid[1]));
    check("b.parity_err", 8'(pe_b), 8'(e_perr[1]));
    check("b.frame_err", 8'(fe_b), 8'(e_ferr[1]));
    check("b.busy", 8'(bz_b), 8'(e_busy[1]));
  endtask

  task automatic sa(input bit s, input bit b, input bit i);
    step(s, b, i, 0, 0, 0, 0);
  endtask

  task automatic frame_a(input logic [7:0] w, input bit p);
    sa(1, 0, 0);
    for (int j = 7; j >= 0; j--) sa(0, 1, w[j]);
    sa(0, 1, p);
  endtask

  typedef struct {
    bit st, be, si;
    logic [7:0] d;
    bit v, pe, fe, bz;
  } vec_t;
  vec_t tv[10];

  initial begin
    int vcnt, fcnt;
    logic [7:0] pat;
    pat = 8'hA5;
    tv[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 1};
    for (int j = 0; j < 8; j++) tv[j+1] = '{0, 1, pat[7-j], 8'h00, 0, 0, 0, 1};
    tv[9] = '{0, 1, 0, 8'hA5, 1, 0, 0, 0};

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset.data_out", do_a, 8'h00);
    check("reset.busy", 8'(bz_a), 8'h00);

    // nominal 0xA5 frame with good parity, checked against fixed expectations
    for (int t = 0; t < 10; t++) begin
      sa(tv[t].st, tv[t].be, tv[t].si);
      check("tbl.data_out", do_a, tv[t].d);
      check("tbl.data_valid", 8'(dv_a), 8'(tv[t].v));
      check("tbl.parity_err", 8'(pe_a), 8'(tv[t].pe));
      check("tbl.frame_err", 8'(fe_a), 8'(tv[t].fe));
      check("tbl.busy", 8'(bz_a), 8'(tv[t].bz));
    end
    sa(0, 0, 0);
    check("hold.data_out", do_a, 8'hA5);
    check("hold.data_valid", 8'(dv_a), 8'h00);

    frame_a(8'hA5, 1);
    check("badpar.data_out", do_a, 8'hA5);
    check("badpar.valid", 8'(dv_a), 8'h01);
    check("badpar.perr", 8'(pe_a), 8'h01);
    sa(0, 0, 0);
    check("badpar.perr_pulse", 8'(pe_a), 8'h00);

    // abort after 4 bits, then a complete 0x5A frame
    vcnt = 0; fcnt = 0;
    sa(1, 0, 0);
    for (int j = 0; j < 4; j++) sa(0, 1, 1'(j));
    sa(1, 1, 1);
    fcnt += int'(fe_a);
    check("abort.frame_err", 8'(fe_a), 8'h01);
    check("abort.data_held", do_a, 8'hA5);
    pat = 8'h5A;
    for (int j = 7; j >= 0; j--) begin
      sa(0, 1, pat[j]); vcnt += int'(dv_a); fcnt += int'(fe_a);
      if (j > 0) check("abort.data_held2", do_a, 8'hA5);
    end
    sa(0, 1, 0); vcnt += int'(dv_a); fcnt += int'(fe_a);
    check("abort.data_out", do_a, 8'h5A);
    check("abort.valid_count", 8'(vcnt), 8'd1);
    check("abort.ferr_count", 8'(fcnt), 8'd1);

    // start arriving together with the last data bit aborts the frame
    sa(1, 0, 0);
    for (int j = 0; j < 7; j++) sa(0, 1, 1);
    sa(1, 1, 1);
    check("lastbit_abort.ferr", 8'(fe_a), 8'h01);
    sa(0, 1, 0);
    check("lastbit_abort.busy", 8'(bz_a), 8'h01);
    sa(1, 0, 0);
    check("lastbit_abort.ferr2", 8'(fe_a), 8'h01);
    step(0, 0, 0, 0, 0, 0, 1);

    // LSB-first 0x3C with a gap after every bit on the no-parity instance
    pat = 8'h3C;
    step(0, 0, 0, 1, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 0, 1, pat[j], 0);
      if (j < 7) step(0, 0, 0, 0, 0, ~pat[j], 0);
    end
    check("gap.data_out", do_b, 8'h3C);
    check("gap.valid", 8'(dv_b), 8'h01);
    check("gap.busy", 8'(bz_b), 8'h00);

    // reset after three bits, then idle noise
    sa(1, 0, 0);
    for (int j = 0; j < 3; j++) sa(0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    check("rst.data_out", do_a, 8'h00);
    check("rst.busy", 8'(bz_a), 8'h00);
    check("rst.ferr", 8'(fe_a), 8'h00);
    vcnt = 0;
    for (int j = 0; j < 20; j++) begin
      sa(0, 1'(j), 1'(j >> 1)); vcnt += int'(dv_a) + int'(bz_a);
    end
    check("idle.activity", 8'(vcnt), 8'd0);

    // back-to-back: start in the data_valid cycle of 0xFF
    fcnt = 0;
    frame_a(8'hFF, 0);
    check("b2b.data1", do_a, 8'hFF);
    check("b2b.valid1", 8'(dv_a), 8'h01);
    sa(1, 0, 0); fcnt += int'(fe_a);
    for (int j = 0; j < 8; j++) begin sa(0, 1, 0); fcnt += int'(fe_a); end
    sa(0, 1, 0); fcnt += int'(fe_a);
    check("b2b.data2", do_a, 8'h00);
    check("b2b.valid2", 8'(dv_a), 8'h01);
    check("b2b.ferr_count", 8'(fcnt), 8'd0);

    // random traffic on both instances
    for (int t = 0; t < 3000; t++)
      step($urandom_range(15) == 0, $urandom_range(3) != 0, 1'($urandom),
           $urandom_range(15) == 0, $urandom_range(3) != 0, 1'($urandom),
           $urandom_range(199) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
